exception_pipe: RTL and testbench

Parametrised, pipelined exception tracker for the mipsel32 CPU core. It carries one exception record (valid, PC, branch-delay flag, exception flag, 5-bit ExcCode) per pipeline stage. At each stage it merges the record with that stage's local exception sources using a fixed priority. At the commit stage it raises a registered exception-taken pulse with EPC, flushes every stage and discards wrong-path input for a programmable number of cycles.

---
 rtl/exception_pipe.sv | 174 +++++++++++++++++
 tb/tb_exception_pipe.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exception_pipe.sv
// exception_pipe: per-stage exception record tracker for the mipsel32 core.
// Merges local exception sources, commits at the last stage, flushes and kills.
module exception_pipe #(
    parameter int STAGES      = 4,
    parameter int SRC         = 2,
    parameter int PC_W        = 32,
    parameter int KILL_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    stall,
    input  logic                    in_valid,
    input  logic [PC_W-1:0]         in_pc,
    input  logic                    in_bd,
    input  logic                    in_exception,
    input  logic [4:0]              in_exccode,
    input  logic [STAGES*SRC-1:0]   src_exception,
    input  logic [5*STAGES*SRC-1:0] src_exccode,
    input  logic                    eret,
    output logic                    retire,
    output logic                    exc_taken,
    output logic [4:0]              exc_code,
    output logic [PC_W-1:0]         exc_epc,
    output logic                    exc_bd,
    output logic                    killing
);

    typedef struct packed {
        logic            v;
        logic [PC_W-1:0] pc;
        logic            bd;
        logic            e;
        logic [4:0]      code;
    } rec_t;

    typedef enum logic {
        ST_RUN,
        ST_KILL
    } state_t;

    localparam int CNT_W = (KILL_CYCLES > 1) ? $clog2(KILL_CYCLES) : 1;

    rec_t rec_q [STAGES];
    rec_t rec_d [STAGES];
    rec_t mrg   [STAGES];
    rec_t head;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic            retire_q, retire_d;
    logic            taken_q, taken_d;
    logic [4:0]      code_q, code_d;
    logic [PC_W-1:0] epc_q, epc_d;
    logic            bd_q, bd_d;

    logic commit;
    logic flush;

    // Merge each stage record with its local sources; older record wins,
    // then the highest-numbered asserted source.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            mrg[k] = rec_q[k];
            if (!rec_q[k].e) begin
                for (int j = 0; j < SRC; j++) begin
                    if (src_exception[k*SRC+j]) begin
                        mrg[k].e    = 1'b1;
                        mrg[k].code = src_exccode[(k*SRC+j)*5 +: 5];
                    end
                end
            end
            if (!rec_q[k].v) begin
                mrg[k].e = 1'b0;
            end
        end
    end

    assign head   = mrg[STAGES-1];
    assign commit = head.v && !stall;
    assign flush  = commit && (head.e || eret);

    // Next pipeline contents: flush clears all, stall holds, else shift.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            rec_d[k] = rec_q[k];
        end
        if (flush) begin
            for (int k = 0; k < STAGES; k++) begin
                rec_d[k].v = 1'b0;
            end
        end else if (!stall) begin
            rec_d[0].v    = in_valid && (state_q == ST_RUN);
            rec_d[0].pc   = in_pc;
            rec_d[0].bd   = in_bd;
            rec_d[0].e    = in_exception;
            rec_d[0].code = in_exccode;
            for (int k = 1; k < STAGES; k++) begin
                rec_d[k] = mrg[k-1];
            end
        end
    end

    // Commit-stage outputs; exception fields hold until the next taken one.
    always_comb begin
        retire_d = commit && !head.e;
        taken_d  = commit && head.e;
        code_d   = code_q;
        epc_d    = epc_q;
        bd_d     = bd_q;
        if (taken_d) begin
            code_d = head.code;
            bd_d   = head.bd;
            epc_d  = head.bd ? (head.pc - PC_W'(4)) : head.pc;
        end
    end

    // Kill window: drop input for KILL_CYCLES cycles after a flush.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_KILL;
                    cnt_d   = CNT_W'(KILL_CYCLES - 1);
                end
            end
            ST_KILL: begin
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < STAGES; k++) begin
                rec_q[k] <= '0;
            end
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            retire_q <= 1'b0;
            taken_q  <= 1'b0;
            code_q   <= '0;
            epc_q    <= '0;
            bd_q     <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                rec_q[k] <= rec_d[k];
            end
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            retire_q <= retire_d;
            taken_q  <= taken_d;
            code_q   <= code_d;
            epc_q    <= epc_d;
            bd_q     <= bd_d;
        end
    end

    assign retire    = retire_q;
    assign exc_taken = taken_q;
    assign exc_code  = code_q;
    assign exc_epc   = epc_q;
    assign exc_bd    = bd_q;
    assign killing   = (state_q == ST_KILL);

endmodule

// File: tb/tb_exception_pipe.sv
// Bench for exception_pipe: instruction-level queue model checked every
// cycle, plus directed scenarios with hand-computed pulse timing.
module tb_exception_pipe;

    localparam int STAGES = 4;
    localparam int SRC    = 2;
    localparam int PC_W   = 32;
    localparam int KC     = 2;

    logic                    clk = 1'b0;
    logic                    resetn = 1'b0;
    logic                    stall = 1'b0;
    logic                    in_valid = 1'b0;
    logic [PC_W-1:0]         in_pc = '0;
    logic                    in_bd = 1'b0;
    logic                    in_exception = 1'b0;
    logic [4:0]              in_exccode = '0;
    logic [STAGES*SRC-1:0]   src_exception = '0;
    logic [5*STAGES*SRC-1:0] src_exccode = '0;
    logic                    eret = 1'b0;
    logic                    retire, exc_taken, exc_bd, killing;
    logic [4:0]              exc_code;
    logic [PC_W-1:0]         exc_epc;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    exception_pipe #(
        .STAGES(STAGES), .SRC(SRC), .PC_W(PC_W), .KILL_CYCLES(KC)
    ) dut (
        .clk(clk), .resetn(resetn), .stall(stall),
        .in_valid(in_valid), .in_pc(in_pc), .in_bd(in_bd),
        .in_exception(in_exception), .in_exccode(in_exccode),
        .src_exception(src_exception), .src_exccode(src_exccode),
        .eret(eret), .retire(retire), .exc_taken(exc_taken),
        .exc_code(exc_code), .exc_epc(exc_epc), .exc_bd(exc_bd),
        .killing(killing)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [PC_W-1:0] pc;
        logic            bd;
        logic            e;
        logic [4:0]      code;
        int              stg;
    } ins_t;

    ins_t            pipe[$];
    int              kill_left = 0;
    logic            exp_retire = 0, exp_taken = 0, exp_bd = 0, exp_kill = 0;
    logic [4:0]      exp_code = 0;
    logic [PC_W-1:0] exp_epc = 0;

    initial forever begin : model
        bit fl;
        bit blocked;
        bit found;
        ins_t n;
        @(posedge clk or negedge resetn);
        if (!resetn) begin
            pipe.delete();
            kill_left  = 0;
            exp_retire = 0;
            exp_taken  = 0;
            exp_code   = 0;
            exp_epc    = 0;
            exp_bd     = 0;
        end else begin
            fl         = 0;
            exp_retire = 0;
            exp_taken  = 0;
            blocked    = (kill_left > 0);
            if (kill_left > 0) kill_left--;
            if (!stall) begin
                foreach (pipe[i]) begin
                    if (!pipe[i].e) begin
                        found = 0;
                        for (int j = SRC - 1; j >= 0; j--) begin
                            if (!found && src_exception[pipe[i].stg*SRC+j]) begin
                                found        = 1;
                                pipe[i].e    = 1;
                                pipe[i].code = src_exccode[(pipe[i].stg*SRC+j)*5 +: 5];
                            end
                        end
                    end
                end
                if (pipe.size() > 0 && pipe[0].stg == STAGES - 1) begin
                    if (pipe[0].e) begin
                        exp_taken = 1;
                        exp_code  = pipe[0].code;
                        exp_bd    = pipe[0].bd;
                        exp_epc   = pipe[0].bd ? pipe[0].pc - 32'd4 : pipe[0].pc;
                        fl        = 1;
                    end else begin
                        exp_retire = 1;
                        if (eret) fl = 1;
                    end
                    void'(pipe.pop_front());
                end
                if (fl) begin
                    pipe.delete();
                    kill_left = KC;
                end else begin
                    foreach (pipe[i]) pipe[i].stg++;
                    if (in_valid && !blocked) begin
                        n.pc   = in_pc;
                        n.bd   = in_bd;
                        n.e    = in_exception;
                        n.code = in_exccode;
                        n.stg  = 0;
                        pipe.push_back(n);
                    end
                end
            end
        end
        exp_kill = (kill_left > 0);
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("m_retire", retire, exp_retire);
            check("m_taken", exc_taken, exp_taken);
            check("m_code", exc_code, exp_code);
            check("m_epc", exc_epc, exp_epc);
            check("m_bd", exc_bd, exp_bd);
            check("m_killing", killing, exp_kill);
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [31:0] m_ret, m_tak, m_kil;
    int tk;

    task automatic clr_masks();
        m_ret = 0;
        m_tak = 0;
        m_kil = 0;
        tk    = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (tk < 32) begin
            m_ret[tk] = retire;
            m_tak[tk] = exc_taken;
            m_kil[tk] = killing;
        end
        tk++;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic issue(logic [31:0] pc, logic bd, logic ex, logic [4:0] code);
        in_valid     = 1;
        in_pc        = pc;
        in_bd        = bd;
        in_exception = ex;
        in_exccode   = code;
        tick();
        in_valid     = 0;
        in_bd        = 0;
        in_exception = 0;
        in_exccode   = 0;
    endtask

    task automatic set_src(int k, int j, logic [4:0] code);
        src_exception[k*SRC+j]         = 1'b1;
        src_exccode[(k*SRC+j)*5 +: 5]  = code;
    endtask

    task automatic clr_src();
        src_exception = '0;
        src_exccode   = '0;
    endtask

    initial begin
        clr_masks();
        #12;
        check("rst_retire", retire, 0);
        check("rst_taken", exc_taken, 0);
        check("rst_code", exc_code, 0);
        check("rst_epc", exc_epc, 0);
        check("rst_bd", exc_bd, 0);
        check("rst_killing", killing, 0);
        @(negedge clk);
        resetn = 1;
        chk_en = 1;

        // Clean flow: four back-to-back entries retire on edges 4..7.
        clr_masks();
        for (int i = 0; i < 10; i++) begin
            in_valid = (i < 4);
            in_pc    = 32'h100 + 32'(4 * i);
            tick();
        end
        in_valid = 0;
        check("clean_retire_mask", m_ret, 32'h0F0);
        check("clean_no_taken", m_tak, 32'h0);

        // Priority: incoming exception beats stage-1 sources.
        issue(32'h300, 0, 1, 5'h0C);
        tick();
        set_src(1, 0, 5'h04);
        set_src(1, 1, 5'h0A);
        tick();
        clr_src();
        tick();
        tick();
        check("prio_in_taken", exc_taken, 1);
        check("prio_in_code", exc_code, 5'h0C);
        check("prio_in_epc", exc_epc, 32'h300);
        idle(4);

        // Priority: source 1 beats source 0.
        issue(32'h310, 0, 0, 5'h00);
        tick();
        set_src(1, 0, 5'h04);
        set_src(1, 1, 5'h0A);
        tick();
        clr_src();
        tick();
        tick();
        check("prio_src_taken", exc_taken, 1);
        check("prio_src_code", exc_code, 5'h0A);
        idle(4);

        // Delay slot EPC.
        issue(32'h8000_0004, 1, 0, 5'h00);
        tick();
        tick();
        set_src(2, 0, 5'h08);
        tick();
        clr_src();
        tick();
        check("bd_taken", exc_taken, 1);
        check("bd_code", exc_code, 5'h08);
        check("bd_epc", exc_epc, 32'h8000_0000);
        check("bd_flag", exc_bd, 1);
        tick();
        check("bd_pulse_once", exc_taken, 0);
        idle(3);

        issue(32'h0000_0000, 1, 0, 5'h00);
        tick();
        tick();
        set_src(2, 0, 5'h08);
        tick();
        clr_src();
        tick();
        check("bd_wrap_epc", exc_epc, 32'hFFFF_FFFC);
        check("bd_wrap_flag", exc_bd, 1);
        idle(4);

        // Flush and kill with in_valid held high through edge 7.
        clr_masks();
        for (int i = 0; i < 15; i++) begin
            in_valid     = (i <= 7);
            in_pc        = 32'h200 + 32'(4 * i);
            in_exception = (i == 0);
            in_exccode   = 5'h0C;
            tick();
        end
        in_valid     = 0;
        in_exception = 0;
        in_exccode   = 0;
        check("kill_taken_mask", m_tak, 32'h010);
        check("kill_killing_mask", m_kil, 32'h030);
        check("kill_retire_mask", m_ret, 32'h800);

        // Stall holds an excepting commit entry.
        issue(32'h400, 0, 1, 5'h11);
        tick();
        tick();
        tick();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_no_taken", exc_taken, 0);
        end
        stall = 0;
        tick();
        check("stall_release_taken", exc_taken, 1);
        check("stall_release_code", exc_code, 5'h11);
        idle(4);

        // Exception and eret together: exception wins.
        issue(32'h500, 0, 1, 5'h0C);
        tick();
        tick();
        tick();
        eret = 1;
        tick();
        eret = 0;
        check("eret_exc_taken", exc_taken, 1);
        check("eret_exc_retire", retire, 0);
        idle(4);

        // Eret alone retires and kills; then reset mid-kill.
        issue(32'h504, 0, 0, 5'h00);
        tick();
        tick();
        tick();
        eret = 1;
        tick();
        eret = 0;
        check("eret_retire", retire, 1);
        check("eret_killing", killing, 1);
        check("eret_no_taken", exc_taken, 0);
        #1 resetn = 0;
        #1;
        check("rstk_retire", retire, 0);
        check("rstk_killing", killing, 0);
        check("rstk_code", exc_code, 0);
        check("rstk_epc", exc_epc, 0);
        @(negedge clk);
        resetn = 1;

        // Eret with empty commit stage is ignored.
        eret = 1;
        tick();
        eret = 0;
        check("eret_idle_killing", killing, 0);
        check("eret_idle_retire", retire, 0);

        // Pipe works again after reset.
        clr_masks();
        issue(32'h600, 0, 0, 5'h00);
        idle(5);
        check("post_rst_retire_mask", m_ret, 32'h010);

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
